// File: rtl/l1_cache_pkg.sv
// ---------------------------------------------------------------------------
// l1_cache_pkg : shared widths, FSM state and block type for the L1 cache
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package l1_cache_pkg;
   localparam int L1_ADDR_WIDTH = 11;
   localparam int L1_DATA_WIDTH = 8;
   localparam int L1_CACHE_SIZE = 256;
   localparam int L1_BLOCK_SIZE = 16;
   localparam int L1_NUM_WAYS   = 4;

   localparam int NUM_SETS = L1_CACHE_SIZE / (L1_BLOCK_SIZE * L1_NUM_WAYS);
   localparam int OFFSET_W = $clog2(L1_BLOCK_SIZE);
   localparam int INDEX_W  = $clog2(NUM_SETS);
   localparam int TAG_W    = L1_ADDR_WIDTH - OFFSET_W - INDEX_W;
   localparam int WAY_W    = $clog2(L1_NUM_WAYS);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_FILL      = 2'd2
   } state_t;

   typedef logic [L1_BLOCK_SIZE*L1_DATA_WIDTH-1:0] block_t;
endpackage

`default_nettype wire

// File: rtl/l1_tag_compare.sv
// ---------------------------------------------------------------------------
// l1_tag_compare : parallel tag/valid match across all ways of one set
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module l1_tag_compare
   import l1_cache_pkg::*;
#(
   parameter int NUM_WAYS = L1_NUM_WAYS
) (
   input  logic [NUM_WAYS-1:0]            valid,
   input  logic [NUM_WAYS-1:0][TAG_W-1:0] tags,
   input  logic [TAG_W-1:0]               tag,
   output logic                           hit,
   output logic [$clog2(NUM_WAYS)-1:0]    way
);
   localparam int WW = $clog2(NUM_WAYS);

   logic [NUM_WAYS-1:0] w_match;

   generate
      for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
         assign w_match[g] = valid[g] && (tags[g] == tag);
      end
   endgenerate

   assign hit = |w_match;

   always_comb begin
      way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (w_match[w]) way = WW'(w);
      end
   end
endmodule

`default_nettype wire

// File: rtl/l1_cache.sv
// ---------------------------------------------------------------------------
// l1_cache : set-associative write-back/write-allocate L1 data cache
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module l1_cache
   import l1_cache_pkg::*;
#(
   parameter int ADDR_WIDTH = L1_ADDR_WIDTH,
   parameter int DATA_WIDTH = L1_DATA_WIDTH,
   parameter int CACHE_SIZE = L1_CACHE_SIZE,
   parameter int BLOCK_SIZE = L1_BLOCK_SIZE,
   parameter int NUM_WAYS   = L1_NUM_WAYS
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [ADDR_WIDTH-1:0]            cpu_addr,
   input  logic [DATA_WIDTH-1:0]            cpu_data_in,
   input  logic                             cpu_read,
   input  logic                             cpu_write,
   output logic [DATA_WIDTH-1:0]            cpu_data_out,
   output logic                             cpu_ready,
   output logic                             l1_hit,
   output logic [ADDR_WIDTH-1:0]            l2_cache_addr,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_out,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_in,
   output logic                             l2_cache_read,
   output logic                             l2_cache_write,
   input  logic                             l2_cache_ready,
   input  logic                             l2_cache_hit
);
   localparam int SETS = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);

   logic [TAG_W-1:0]    w_tag;
   logic [INDEX_W-1:0]  w_index;
   logic [OFFSET_W-1:0] w_offset;
   assign {w_tag, w_index, w_offset} = cpu_addr;

   state_t                             r_state;
   logic [NUM_WAYS-1:0]                r_valid [SETS];
   logic [NUM_WAYS-1:0]                r_dirty [SETS];
   logic [WAY_W-1:0]                   r_ptr   [SETS];
   logic [NUM_WAYS-1:0][TAG_W-1:0]     r_tag   [SETS];
   logic [BLOCK_SIZE*DATA_WIDTH-1:0]   r_data  [SETS][NUM_WAYS];
   logic [TAG_W-1:0]                   r_req_tag;
   logic [INDEX_W-1:0]                 r_req_index;
   logic [WAY_W-1:0]                   r_victim;

   logic                               w_tag_hit;
   logic [WAY_W-1:0]                   w_hit_way;
   logic [WAY_W-1:0]                   w_victim;
   logic                               w_req;
   logic                               w_hit;
   logic [BLOCK_SIZE*DATA_WIDTH-1:0]   w_hit_block;
   logic                               w_fill_done;

   // The next-level hit flag carries no control meaning here.
   logic unused_l2_hit;
   assign unused_l2_hit = l2_cache_hit;

   l1_tag_compare #(.NUM_WAYS(NUM_WAYS)) u_tag_compare (
      .valid (r_valid[w_index]),
      .tags  (r_tag[w_index]),
      .tag   (w_tag),
      .hit   (w_tag_hit),
      .way   (w_hit_way)
   );

   assign w_req       = cpu_read | cpu_write;
   assign w_hit       = (r_state == ST_IDLE) && w_req && w_tag_hit;
   assign w_hit_block = r_data[w_index][w_hit_way];
   assign w_fill_done = (r_state == ST_FILL) && l2_cache_ready;

   assign l1_hit       = w_hit;
   assign cpu_ready    = w_hit;
   assign cpu_data_out = w_hit ? w_hit_block[DATA_WIDTH*int'(w_offset) +: DATA_WIDTH] : '0;

   assign l2_cache_data_out = (r_state == ST_WRITEBACK) ? r_data[r_req_index][r_victim] : '0;

   // Lowest-numbered invalid way wins; a full set falls back to round-robin.
   always_comb begin
      w_victim = r_ptr[w_index];
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w_index][w]) w_victim = WAY_W'(w);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         l2_cache_read  <= 1'b0;
         l2_cache_write <= 1'b0;
         l2_cache_addr  <= '0;
         r_req_tag      <= '0;
         r_req_index    <= '0;
         r_victim       <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            r_ptr[s]   <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req && !w_tag_hit) begin
                  r_req_tag   <= w_tag;
                  r_req_index <= w_index;
                  r_victim    <= w_victim;
                  if (r_dirty[w_index][w_victim]) begin
                     r_state        <= ST_WRITEBACK;
                     l2_cache_write <= 1'b1;
                     l2_cache_addr  <= {r_tag[w_index][w_victim], w_index, {OFFSET_W{1'b0}}};
                  end else begin
                     r_state       <= ST_FILL;
                     l2_cache_read <= 1'b1;
                     l2_cache_addr <= {w_tag, w_index, {OFFSET_W{1'b0}}};
                  end
               end else if (w_hit && cpu_write) begin
                  r_dirty[w_index][w_hit_way] <= 1'b1;
               end
            end
            ST_WRITEBACK: begin
               if (l2_cache_ready) begin
                  r_state        <= ST_FILL;
                  l2_cache_write <= 1'b0;
                  l2_cache_read  <= 1'b1;
                  l2_cache_addr  <= {r_req_tag, r_req_index, {OFFSET_W{1'b0}}};
               end
            end
            ST_FILL: begin
               if (l2_cache_ready) begin
                  r_state                        <= ST_IDLE;
                  l2_cache_read                  <= 1'b0;
                  l2_cache_addr                  <= '0;
                  r_valid[r_req_index][r_victim] <= 1'b1;
                  r_dirty[r_req_index][r_victim] <= 1'b0;
                  if (r_valid[r_req_index][r_victim])
                     r_ptr[r_req_index] <= r_ptr[r_req_index] + WAY_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Line contents are qualified by valid, so the arrays need no reset.
   always_ff @(posedge clk) begin
      if (w_fill_done) begin
         r_data[r_req_index][r_victim] <= l2_cache_data_in;
         r_tag[r_req_index][r_victim]  <= r_req_tag;
      end else if (w_hit && cpu_write) begin
         r_data[w_index][w_hit_way][DATA_WIDTH*int'(w_offset) +: DATA_WIDTH] <= cpu_data_in;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_l1_cache.sv
// ---------------------------------------------------------------------------
// tb_l1_cache : directed scoreboard bench for l1_cache with a block memory model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_l1_cache;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [10:0]  cpu_addr = '0;
   logic [7:0]   cpu_data_in = '0;
   logic         cpu_read = 1'b0;
   logic         cpu_write = 1'b0;
   logic [7:0]   cpu_data_out;
   logic         cpu_ready;
   logic         l1_hit;
   logic [10:0]  l2_cache_addr;
   logic [127:0] l2_cache_data_out;
   logic [127:0] l2_cache_data_in;
   logic         l2_cache_read;
   logic         l2_cache_write;
   logic         l2_cache_ready;
   logic         l2_cache_hit;

   int n_cmp = 0;
   int n_mis = 0;
   logic [7:0] sb[$];

   // memory model state
   logic [7:0]   mem [2048];
   int           mcnt;
   int           rd_cnt, wr_cnt;
   logic [10:0]  last_rd_addr, last_wb_addr;
   logic [127:0] last_wb_data;

   always #5 clk = ~clk;

   l1_cache dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cpu_addr          (cpu_addr),
      .cpu_data_in       (cpu_data_in),
      .cpu_read          (cpu_read),
      .cpu_write         (cpu_write),
      .cpu_data_out      (cpu_data_out),
      .cpu_ready         (cpu_ready),
      .l1_hit            (l1_hit),
      .l2_cache_addr     (l2_cache_addr),
      .l2_cache_data_out (l2_cache_data_out),
      .l2_cache_data_in  (l2_cache_data_in),
      .l2_cache_read     (l2_cache_read),
      .l2_cache_write    (l2_cache_write),
      .l2_cache_ready    (l2_cache_ready),
      .l2_cache_hit      (l2_cache_hit)
   );

   // Backing store: byte[a] = a[7:0] at reset, 3-cycle count then a 1-cycle ready pulse.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 8'(i);
         mcnt             <= 0;
         l2_cache_ready   <= 1'b0;
         l2_cache_hit     <= 1'b0;
         l2_cache_data_in <= '0;
         rd_cnt           <= 0;
         wr_cnt           <= 0;
         last_rd_addr     <= '0;
         last_wb_addr     <= '0;
         last_wb_data     <= '0;
      end else begin
         l2_cache_ready <= 1'b0;
         l2_cache_hit   <= 1'b0;
         if ((l2_cache_read || l2_cache_write) && !l2_cache_ready) begin
            if (mcnt == 2) begin
               mcnt           <= 0;
               l2_cache_ready <= 1'b1;
               l2_cache_hit   <= 1'b1;
               if (l2_cache_write) begin
                  for (int k = 0; k < 16; k++)
                     mem[{l2_cache_addr[10:4], 4'(k)}] <= l2_cache_data_out[k*8 +: 8];
                  wr_cnt       <= wr_cnt + 1;
                  last_wb_addr <= l2_cache_addr;
                  last_wb_data <= l2_cache_data_out;
               end else begin
                  for (int k = 0; k < 16; k++)
                     l2_cache_data_in[k*8 +: 8] <= mem[{l2_cache_addr[10:4], 4'(k)}];
                  rd_cnt       <= rd_cnt + 1;
                  last_rd_addr <= l2_cache_addr;
               end
            end else begin
               mcnt <= mcnt + 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the request has been dropped.
   task automatic cpu_access(input string tag, input logic [10:0] a, input bit wr,
                             input logic [7:0] wd, input logic [7:0] exp, input bit exp_hit);
      int cyc;
      bit first_hit;
      int rd0, wr0;
      logic [7:0] e;
      sb.push_back(exp);
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      cpu_addr    = a;
      cpu_data_in = wd;
      cpu_read    = !wr;
      cpu_write   = wr;
      #1;
      first_hit = cpu_ready;
      cyc = 0;
      while (!cpu_ready && cyc < 200) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_done"}, 32'(cpu_ready), 32'd1);
      if (cpu_ready) begin
         e = sb.pop_front();
         chk({tag, "_data"}, 32'(cpu_data_out), 32'(e));
      end else begin
         void'(sb.pop_front());
      end
      chk({tag, "_first_cycle_hit"}, 32'(first_hit), 32'(exp_hit));
      if (exp_hit)
         chk({tag, "_l2_traffic"}, 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
      @(negedge clk);
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
   endtask

   initial begin
      int cyc;
      int wr_before;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("rst_l1_hit", 32'(l1_hit), 32'd0);
      chk("rst_data_out", 32'(cpu_data_out), 32'd0);
      chk("rst_l2_ctl", {30'd0, l2_cache_read, l2_cache_write}, 32'd0);
      chk("rst_l2_addr", 32'(l2_cache_addr), 32'd0);
      @(negedge clk);

      cpu_access("rd001", 11'h001, 1'b0, 8'h00, 8'h01, 1'b0);
      chk("rd001_fill_addr", 32'(last_rd_addr), 32'h000);
      cpu_access("rd000", 11'h000, 1'b0, 8'h00, 8'h00, 1'b1);
      cpu_access("rd002", 11'h002, 1'b0, 8'h00, 8'h02, 1'b1);
      cpu_access("rd005", 11'h005, 1'b0, 8'h00, 8'h05, 1'b1);

      cpu_access("rd010", 11'h010, 1'b0, 8'h00, 8'h10, 1'b0);
      chk("rd010_fill_addr", 32'(last_rd_addr), 32'h010);
      cpu_access("rd014", 11'h014, 1'b0, 8'h00, 8'h14, 1'b1);
      cpu_access("rd01A", 11'h01A, 1'b0, 8'h00, 8'h1A, 1'b1);

      cpu_access("rd101", 11'h101, 1'b0, 8'h00, 8'h01, 1'b0);
      cpu_access("rd001b", 11'h001, 1'b0, 8'h00, 8'h01, 1'b1);

      // Store hit returns the pre-store byte on cpu_data_out.
      cpu_access("wr003", 11'h003, 1'b1, 8'hAA, 8'h03, 1'b1);
      wr_before = wr_cnt;
      cpu_access("rd041", 11'h041, 1'b0, 8'h00, 8'h41, 1'b0);
      cpu_access("rd081", 11'h081, 1'b0, 8'h00, 8'h81, 1'b0);
      chk("no_wb_yet", 32'(wr_cnt - wr_before), 32'd0);
      cpu_access("rd0C1", 11'h0C1, 1'b0, 8'h00, 8'hC1, 1'b0);
      chk("evict_wb_count", 32'(wr_cnt - wr_before), 32'd1);
      chk("evict_wb_addr", 32'(last_wb_addr), 32'h000);
      chk("evict_wb_byte3", 32'(last_wb_data[3*8 +: 8]), 32'hAA);
      chk("evict_wb_byte4", 32'(last_wb_data[4*8 +: 8]), 32'h04);
      cpu_access("rd101b", 11'h101, 1'b0, 8'h00, 8'h01, 1'b1);
      cpu_access("rd003", 11'h003, 1'b0, 8'h00, 8'hAA, 1'b0);
      chk("rd003_fill_addr", 32'(last_rd_addr), 32'h000);

      // Reset in the middle of a fill.
      cpu_addr = 11'h200;
      cpu_read = 1'b1;
      cyc = 0;
      while (!l2_cache_read && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("midfill_read_seen", 32'(l2_cache_read), 32'd1);
      chk("midfill_read_addr", 32'(l2_cache_addr), 32'h200);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midfill_rst_l2_read", 32'(l2_cache_read), 32'd0);
      chk("midfill_rst_l2_addr", 32'(l2_cache_addr), 32'd0);
      chk("midfill_rst_ready", {30'd0, cpu_ready, l1_hit}, 32'd0);
      chk("midfill_rst_data", 32'(cpu_data_out), 32'd0);
      cpu_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cpu_access("rd001_post_rst", 11'h001, 1'b0, 8'h00, 8'h01, 1'b0);
      cpu_access("rd200_post_rst", 11'h200, 1'b0, 8'h00, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

`default_nettype wire
